// File: rtl/dup_inst_packer.sv
// Duplicate-instruction packer: compacts the valid lanes of an 8-lane bundle into one
// multi-write for the QED duplicate FIFO. Define DUP_INST_REG_REMAP_EN to XOR register fields.
module dup_inst_packer #(
  parameter int         INST_WIDTH = 32,
  parameter logic [4:0] REMAP_MASK = 5'b10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    qed_en,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*INST_WIDTH-1:0] in_inst,
  input  logic [7:0]              in_mask,
  input  logic                    fifo_almost_full,
  output logic                    fifo_wt,
  output logic [3:0]              instruction_num,
  output logic [INST_WIDTH-1:0]   fifo_wdata_0,
  output logic [INST_WIDTH-1:0]   fifo_wdata_1,
  output logic [INST_WIDTH-1:0]   fifo_wdata_2,
  output logic [INST_WIDTH-1:0]   fifo_wdata_3,
  output logic [INST_WIDTH-1:0]   fifo_wdata_4,
  output logic [INST_WIDTH-1:0]   fifo_wdata_5,
  output logic [INST_WIDTH-1:0]   fifo_wdata_6,
  output logic [INST_WIDTH-1:0]   fifo_wdata_7,
  output logic [15:0]             dup_count,
  output logic [1:0]              dbg_state,
  output logic                    dbg_stage_v
);

  // Handshake: a bundle transfers on a rising edge where in_valid & in_ready are both 1;
  // in_ready never depends on in_valid, and an upstream bundle is held until it transfers.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                state;
  logic                  stage_v;
  logic [3:0]            stage_num;
  logic [INST_WIDTH-1:0] stage_data [8];

  logic [INST_WIDTH-1:0] lane_in   [8];
  logic [INST_WIDTH-1:0] comp_data [8];
  logic [3:0]            comp_num;
  logic                  fire;
  logic                  accept;
  logic                  load;
  logic [16:0]           dup_sum;

  // SYSTEM instructions carry no architectural register pair to shadow, so they pass as-is.
  function automatic logic [INST_WIDTH-1:0] remap_lane(input logic [INST_WIDTH-1:0] inst);
    remap_lane = inst;
    if (inst[6:0] != 7'b1110011) begin
      remap_lane[11:7]  = inst[11:7]  ^ REMAP_MASK;
      remap_lane[19:15] = inst[19:15] ^ REMAP_MASK;
      remap_lane[24:20] = inst[24:20] ^ REMAP_MASK;
    end
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
`ifdef DUP_INST_REG_REMAP_EN
      lane_in[k] = remap_lane(in_inst[k*INST_WIDTH +: INST_WIDTH]);
`else
      lane_in[k] = in_inst[k*INST_WIDTH +: INST_WIDTH];
`endif
    end
  end

  // Output lane j takes the j-th set mask bit counting up from lane 0; unused lanes stay zero.
  always_comb begin
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int j = 0; j < 8; j++) begin
      comp_data[j] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      if (in_mask[k]) begin
        comp_data[cnt[2:0]] = lane_in[k];
        cnt = cnt + 4'd1;
      end
    end
    comp_num = cnt;
  end

  assign fire   = stage_v & ~fifo_almost_full & ~flush;
  assign accept = in_valid & in_ready;
  assign load   = accept & (state == S_ACTIVE) & qed_en & (comp_num != 4'd0);

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:   in_ready = ~flush;
      S_ACTIVE: in_ready = ~flush & (~stage_v | fire);
      default:  in_ready = 1'b0;
    endcase
  end

  assign dup_sum = {1'b0, dup_count} + {13'd0, stage_num};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stage_v   <= 1'b0;
      stage_num <= 4'd0;
      dup_count <= 16'd0;
      for (int k = 0; k < 8; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      if (fire) begin
        dup_count <= dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
      end
      if (flush) begin
        stage_v <= 1'b0;
        state   <= qed_en ? S_ACTIVE : S_IDLE;
      end else begin
        if (load) begin
          stage_v   <= 1'b1;
          stage_num <= comp_num;
          for (int k = 0; k < 8; k++) begin
            stage_data[k] <= comp_data[k];
          end
        end else if (fire) begin
          stage_v <= 1'b0;
        end
        case (state)
          S_IDLE: begin
            if (qed_en) state <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (!qed_en) state <= (stage_v & ~fire) ? S_DRAIN : S_IDLE;
          end
          S_DRAIN: begin
            if (qed_en)    state <= S_ACTIVE;
            else if (fire) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo_wt         = fire;
  assign instruction_num = stage_v ? stage_num : 4'd0;
  assign fifo_wdata_0    = stage_data[0];
  assign fifo_wdata_1    = stage_data[1];
  assign fifo_wdata_2    = stage_data[2];
  assign fifo_wdata_3    = stage_data[3];
  assign fifo_wdata_4    = stage_data[4];
  assign fifo_wdata_5    = stage_data[5];
  assign fifo_wdata_6    = stage_data[6];
  assign fifo_wdata_7    = stage_data[7];
  assign dbg_state       = state;
  assign dbg_stage_v     = stage_v;

endmodule

// File: tb/tb_dup_inst_packer.sv
// Directed bench for dup_inst_packer: hand-computed vectors plus a write scoreboard.
module tb_dup_inst_packer;
  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DRAIN = 2'd2;

  logic clk = 1'b0;
  logic rst, qed_en, flush, in_valid, in_ready;
  logic [8*W-1:0] in_inst;
  logic [7:0] in_mask;
  logic fifo_almost_full, fifo_wt;
  logic [3:0] instruction_num;
  logic [W-1:0] wd [8];
  logic [15:0] dup_count;
  logic [1:0] dbg_state;
  logic dbg_stage_v;

  int n_asserts = 0;
  int n_fail = 0;
  logic [4+8*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  dup_inst_packer #(.INST_WIDTH(W), .REMAP_MASK(5'b10000)) dut (
    .clk(clk), .rst(rst), .qed_en(qed_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_mask(in_mask),
    .fifo_almost_full(fifo_almost_full), .fifo_wt(fifo_wt), .instruction_num(instruction_num),
    .fifo_wdata_0(wd[0]), .fifo_wdata_1(wd[1]), .fifo_wdata_2(wd[2]), .fifo_wdata_3(wd[3]),
    .fifo_wdata_4(wd[4]), .fifo_wdata_5(wd[5]), .fifo_wdata_6(wd[6]), .fifo_wdata_7(wd[7]),
    .dup_count(dup_count), .dbg_state(dbg_state), .dbg_stage_v(dbg_stage_v)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_l(input logic [W-1:0] x);
    exp_l = x;
`ifdef DUP_INST_REG_REMAP_EN
    if (x[6:0] != 7'b1110011) begin
      exp_l[11:7]  = x[11:7]  ^ 5'b10000;
      exp_l[19:15] = x[19:15] ^ 5'b10000;
      exp_l[24:20] = x[24:20] ^ 5'b10000;
    end
`endif
  endfunction

  task automatic push_exp(input logic [3:0] num, input logic [8*W-1:0] lanes, input bit remap);
    logic [8*W-1:0] l;
    l = lanes;
    if (remap) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(num)) l[k*W +: W] = exp_l(lanes[k*W +: W]);
      end
    end
    exp_q.push_back({num, l});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] m, input logic [W-1:0] base);
    in_valid = v;
    in_mask  = m;
    for (int k = 0; k < 8; k++) in_inst[k*W +: W] = base + W'(k);
  endtask

  // Scoreboard: every write must match the oldest expected bundle.
  always @(negedge clk) begin
    if (fifo_wt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_wt", 32'd1, 32'd0);
      end else begin
        logic [4+8*W-1:0] e;
        e = exp_q.pop_front();
        check_val("sb_num", {28'd0, instruction_num}, {28'd0, e[8*W +: 4]});
        for (int k = 0; k < 8; k++) check_val("sb_lane", wd[k], e[k*W +: W]);
      end
    end
  end

  initial begin
    logic [8*W-1:0] sat_lanes;
    rst = 1'b1; qed_en = 1'b0; flush = 1'b0; fifo_almost_full = 1'b0;
    in_inst = '0;
    drive(1'b1, 8'hFF, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle discard
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_fifo_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("rst_dup_count", {16'd0, dup_count}, 32'd0);
    check_val("rst_num", {28'd0, instruction_num}, 32'd0);
    check_val("rst_wdata0", wd[0], 32'd0);
    check_val("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check_val("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("idle_fifo_wt", {31'd0, fifo_wt}, 32'd0);
      check_val("idle_dup_count", {16'd0, dup_count}, 32'd0);
    end

    // Compaction
    cyc(); qed_en = 1'b1; in_valid = 1'b0;
    cyc(); drive(1'b1, 8'b1010_0101, 32'h100);
    push_exp(4'd4, {32'h0, 32'h0, 32'h0, 32'h0, 32'h107, 32'h105, 32'h102, 32'h100}, 1'b1);
    @(negedge clk);
    check_val("cmp_state", {30'd0, dbg_state}, {30'd0, ST_ACTIVE});
    check_val("cmp_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check_val("cmp_fifo_wt", {31'd0, fifo_wt}, 32'd1);
    check_val("cmp_num", {28'd0, instruction_num}, 32'd4);
    check_val("cmp_wd0", wd[0], exp_l(32'h100));
    check_val("cmp_wd1", wd[1], exp_l(32'h102));
    check_val("cmp_wd2", wd[2], exp_l(32'h105));
    check_val("cmp_wd3", wd[3], exp_l(32'h107));
    check_val("cmp_wd4", wd[4], 32'h0);
    check_val("cmp_wd7", wd[7], 32'h0);
    cyc();
    @(negedge clk);
    check_val("cmp_dup_count", {16'd0, dup_count}, 32'd4);
    check_val("cmp_wt_done", {31'd0, fifo_wt}, 32'd0);

    // Backpressure with a second bundle waiting
    cyc(); drive(1'b1, 8'h0F, 32'h200);
    push_exp(4'd4, {128'h0, 32'h203, 32'h202, 32'h201, 32'h200}, 1'b1);
    cyc(); fifo_almost_full = 1'b1; drive(1'b1, 8'h03, 32'h300);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_fifo_wt", {31'd0, fifo_wt}, 32'd0);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    fifo_almost_full = 1'b0;
    push_exp(4'd2, {192'h0, 32'h301, 32'h300}, 1'b1);
    @(negedge clk);
    check_val("bp_rel_wt", {31'd0, fifo_wt}, 32'd1);
    check_val("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp_rel_num", {28'd0, instruction_num}, 32'd4);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_second_wt", {31'd0, fifo_wt}, 32'd1);
    check_val("bp_second_num", {28'd0, instruction_num}, 32'd2);
    check_val("bp_second_wd2", wd[2], 32'h0);
    cyc();
    @(negedge clk);
    check_val("bp_dup_count", {16'd0, dup_count}, 32'd10);

    // Empty bundle is consumed and dropped
    cyc(); drive(1'b1, 8'h00, 32'h280);
    @(negedge clk);
    check_val("empty_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check_val("empty_fifo_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("empty_stage_v", {31'd0, dbg_stage_v}, 32'd0);
    check_val("empty_dup_count", {16'd0, dup_count}, 32'd10);

    // Drain: qed_en drops with a stalled stage
    cyc(); drive(1'b1, 8'h80, 32'h400);
    push_exp(4'd1, {224'h0, 32'h407}, 1'b1);
    cyc(); in_valid = 1'b0; fifo_almost_full = 1'b1;
    @(negedge clk);
    check_val("drn_stall_wt", {31'd0, fifo_wt}, 32'd0);
    cyc(); qed_en = 1'b0;
    @(negedge clk);
    check_val("drn_pre_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(); drive(1'b1, 8'hFF, 32'h480);
    @(negedge clk);
    check_val("drn_state", {30'd0, dbg_state}, {30'd0, ST_DRAIN});
    check_val("drn_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("drn_hold_wt", {31'd0, fifo_wt}, 32'd0);
    cyc(); fifo_almost_full = 1'b0;
    @(negedge clk);
    check_val("drn_fire_wt", {31'd0, fifo_wt}, 32'd1);
    check_val("drn_fire_num", {28'd0, instruction_num}, 32'd1);
    check_val("drn_fire_wd0", wd[0], exp_l(32'h407));
    check_val("drn_fire_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check_val("drn_idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_val("drn_idle_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("drn_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("drn_dup_count", {16'd0, dup_count}, 32'd11);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check_val("drn_idle_discard", {31'd0, fifo_wt}, 32'd0);

    // Flush a stalled stage: no write
    cyc(); qed_en = 1'b1;
    cyc(); drive(1'b1, 8'h01, 32'h500);
    cyc(); in_valid = 1'b0; fifo_almost_full = 1'b1;
    @(negedge clk);
    check_val("fl_stage_v", {31'd0, dbg_stage_v}, 32'd1);
    cyc(); flush = 1'b1; fifo_almost_full = 1'b0;
    @(negedge clk);
    check_val("fl_fifo_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("fl_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    check_val("fl_cleared", {31'd0, dbg_stage_v}, 32'd0);
    check_val("fl_num", {28'd0, instruction_num}, 32'd0);
    check_val("fl_after_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("fl_state", {30'd0, dbg_state}, {30'd0, ST_ACTIVE});
    check_val("fl_dup_count", {16'd0, dup_count}, 32'd11);

`ifdef DUP_INST_REG_REMAP_EN
    // Register remap: add x3,x1,x2 becomes add x19,x17,x18; ecall untouched
    cyc(); in_valid = 1'b1; in_mask = 8'h03; in_inst = '0;
    in_inst[31:0] = 32'h002081B3; in_inst[63:32] = 32'h00000073;
    push_exp(4'd2, {192'h0, 32'h00000073, 32'h012889B3}, 1'b0);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check_val("remap_wd0", wd[0], 32'h012889B3);
    check_val("remap_wd1", wd[1], 32'h00000073);
`endif

    // Sustained full bundles until the counter saturates
    for (int k = 0; k < 8; k++) sat_lanes[k*W +: W] = 32'h600 + W'(k);
    for (int i = 0; i < 8192; i++) begin
      cyc(); drive(1'b1, 8'hFF, 32'h600);
      push_exp(4'd8, sat_lanes, 1'b1);
      @(negedge clk);
      if (i % 512 == 0) check_val("tput_in_ready", {31'd0, in_ready}, 32'd1);
    end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    check_val("sat_dup_count", {16'd0, dup_count}, 32'h0000FFFF);
    check_val("sat_fifo_wt", {31'd0, fifo_wt}, 32'd0);
    check_val("sb_leftover", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/dup_inst_packer.md
# dup_inst_packer

Upstream feeder for the duplicate-instruction FIFO in the QED path. Accepts an 8-lane fetched/decoded bundle with a per-lane valid mask and compacts the valid lanes in order into contiguous lanes 0..n-1. Holds the result in a one-entry stage register and issues it to the FIFO as one multi-write (`fifo_wt` plus `instruction_num`). Issue is gated by `fifo_almost_full`, and an enable/drain state machine governs the whole flow.

## Interface
- `INST_WIDTH`, 32: instruction width in bits; must be ≥ 25.
- `REMAP_MASK`, 5'b10000: XOR mask applied to register fields when remap is compiled in.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `qed_en`  in  1: capture enable.
- `flush`  in  1: discard the staged bundle.
- `in_valid`  in  1: bundle valid.
- `in_ready`  out  1: bundle accepted when `in_valid & in_ready`.
- `in_inst`  in  8*INST_WIDTH: lane k at bits [k*INST_WIDTH +: INST_WIDTH].
- `in_mask`  in  8: per-lane valid; bit k qualifies lane k.
- `fifo_almost_full`  in  1: from the FIFO; low guarantees room for 8 entries.
- `fifo_wt`  out  1: FIFO write strobe.
- `instruction_num`  out  4: entries written; 1..8 whenever `fifo_wt`=1.
- `fifo_wdata_0` .. `fifo_wdata_7`  out  INST_WIDTH each: compacted lanes.
- `dup_count`  out  16: saturating count of instructions written.

## Operation
- **Compaction:** output lane j is the j-th set bit of `in_mask`, scanning lane 0 upward.
  - `n = popcount(in_mask)`.
  - Lanes ≥ n are driven to 0.
- **Stage register:** `stage_v`, `stage_num[3:0]`, and 8 data lanes.
- **Fire:** `fire = stage_v & ~fifo_almost_full & ~flush`.
  - `fifo_wt = fire`.
  - `instruction_num = stage_v ? stage_num : 0`.
  - Data comes straight from the stage registers.
- **Never write empty:** `fifo_wt` is never asserted with `instruction_num` = 0.
  - An accepted bundle with `in_mask` = 0 is consumed and dropped; the stage is unchanged unless it fires.
- **FSM states:** IDLE, ACTIVE, DRAIN. Reset state is IDLE.
  - **IDLE:**
    - `in_ready` = 1; bundles are consumed and discarded (upstream never stalls).
    - `qed_en` = 1 → ACTIVE.
  - **ACTIVE:**
    - `in_ready = ~flush & (~stage_v | fire)`.
    - An accepted non-empty bundle loads the stage; simultaneous fire and load is allowed (back-to-back bundles).
    - `qed_en` = 0: → DRAIN if `stage_v` and not firing, else → IDLE.
    - No capture in the cycle `qed_en` drops.
  - **DRAIN:**
    - `in_ready` = 0.
    - Waits for `fire`, then → IDLE.
    - `qed_en` reasserted → ACTIVE; the stage is kept.
  - **`flush` (any state):**
    - Clears `stage_v` and suppresses fire and accept that cycle.
    - Next state is ACTIVE if `qed_en`, else IDLE.
- **`dup_count`:** += `instruction_num` on fire; saturates at 16'hFFFF.
- **Reset values:** `stage_v`=0, FSM=IDLE, `dup_count`=0, `fifo_wt`=0, `instruction_num`=0, all `fifo_wdata_*`=0, `in_ready`=1 in the cycle after reset. `rst` mid-operation discards the staged bundle without writing.

## Timing
- Accept at edge N → `fifo_wt` high in cycle N+1 at the earliest. Latency is 1.
- Sustained throughput: one bundle per cycle while `fifo_almost_full`=0.
- `fifo_almost_full` is sampled combinationally in the same cycle. The FIFO count updates one edge after a write, so the deassert-means-8-free guarantee makes any fire safe.
- Stall: while `fifo_almost_full`=1 the stage holds and `in_ready`=0 (ACTIVE with `stage_v`).
- Priority: `rst` > `flush` > fire/accept.

## Configuration
- Macro `DUP_INST_REG_REMAP_EN`.
- **Defined:** before compaction, each valid lane has rd [11:7], rs1 [19:15] and rs2 [24:20] XORed with `REMAP_MASK`, producing EDDI-V duplicates that use the shadow register half. The remap is applied only to lanes whose opcode [6:0] ≠ 7'b1110011 (SYSTEM); those lanes pass unchanged.
- **Undefined:** lanes pass unmodified.
- Latency is identical in both builds.

## Test plan
- **Reset / idle discard:** `rst` 2 cycles, `qed_en`=0, bundle with `in_mask`=8'hFF.
  - `in_ready`=1, `fifo_wt`=0 throughout, `dup_count`=0.
- **Compaction:** `qed_en`=1, `in_mask`=8'b1010_0101, lanes = 32'h100+k.
  - Next cycle `fifo_wt`=1, `instruction_num`=4.
  - wdata_0..3 = 100, 102, 105, 107; wdata_4..7 = 0; `dup_count`=4.
- **Backpressure:** `fifo_almost_full`=1 for 5 cycles with a staged bundle plus a new `in_valid`.
  - `fifo_wt`=0 and `in_ready`=0 for 5 cycles.
  - Staged bundle written in the first cycle after deassert; the second bundle accepted that same cycle and written the next.
- **Empty bundle:** `in_mask`=0 accepted.
  - No `fifo_wt`; `dup_count` unchanged.
- **Drain and flush:**
  - Drop `qed_en` with a stalled stage → DRAIN, `in_ready`=0, single write after `almost_full` falls, then IDLE.
  - Separately, `flush` with a stalled stage → no write, `stage_v`=0.
- **Remap (macro defined):** lane 0 = 32'h002081B3 (add x3,x1,x2).
  - `fifo_wdata_0` = 32'h012889B3.
  - Lane 32'h00000073 is unchanged.
